// File: rtl/fog_uart_tx_packer.sv
// Frames captured FOG error/step words into an 11-byte packet (2 header bytes,
// 8 payload bytes, CRC-8) and shifts it out as back-to-back 8N1 UART bytes.
module fog_uart_tx_packer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HDR_BYTE     = 8'hC0
) (
  input  logic        CLOCK_CPU,
  input  logic        RST,
  input  logic        i_trig,
  input  logic [31:0] i_err,
  input  logic [31:0] i_step,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun,
  output logic [15:0] o_drop_cnt
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_START  = 2'd1;
  localparam logic [1:0]  S_DATA   = 2'd2;
  localparam logic [1:0]  S_STOP   = 2'd3;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  BYTE_LAST = 4'd10;

  // CRC-8, poly 0x07, init 0, MSB-first over the 8 payload bytes.
  function automatic logic [7:0] crc8_64(input logic [63:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [31:0] err_q, err_d;
  logic [31:0] step_q, step_d;
  logic [7:0]  crc_q, crc_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic [7:0]  cur_byte;
  logic        bit_tick;

  always_comb begin
    case (byte_idx_q)
      4'd2:    cur_byte = err_q[31:24];
      4'd3:    cur_byte = err_q[23:16];
      4'd4:    cur_byte = err_q[15:8];
      4'd5:    cur_byte = err_q[7:0];
      4'd6:    cur_byte = step_q[31:24];
      4'd7:    cur_byte = step_q[23:16];
      4'd8:    cur_byte = step_q[15:8];
      4'd9:    cur_byte = step_q[7:0];
      4'd10:   cur_byte = crc_q;
      default: cur_byte = HDR_BYTE;
    endcase
  end

  assign bit_tick = (clk_cnt_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    err_d      = err_q;
    step_d     = step_q;
    crc_d      = crc_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_trig) begin
          state_d    = S_START;
          clk_cnt_d  = 16'd0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 4'd0;
          err_d      = i_err;
          step_d     = i_step;
          crc_d      = crc8_64({i_err, i_step});
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) begin
          clk_cnt_d = 16'd0;
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_d = 16'd0;
          if (byte_idx_q == BYTE_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Next start bit follows the stop bit with no idle gap.
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // busy_q is still high on the completion edge, so a coincident trigger drops.
    if (busy_q && i_trig) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_CPU or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      err_q      <= 32'd0;
      step_q     <= 32'd0;
      crc_q      <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      err_q      <= err_d;
      step_q     <= step_d;
      crc_q      <= crc_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overrun  = overrun_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
